// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control unit.
// Moore-style sequencer: one state per clock, datapath strobes decoded from the
// current state, ImmSrc decoded straight from the opcode.
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction, PC <= PC + 4, latch IR/OldPC
// DECODE   | read registers, ALUOut <= OldPC + imm (branch target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECUTER | ALUOut <= rs1 op rs2
// EXECUTEI | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare rs1 - rs2, PC <= ALUOut when Zero
// JAL      | ALUOut <= OldPC + 4, PC <= jump target
// HALT     | stopped after an illegal opcode, left only by reset
module multicycle_control_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         operation,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOP,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic               halted,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   op_legal;

  assign op_legal  = (operation == OP_LW) || (operation == OP_SW) ||
                     (operation == OP_R)  || (operation == OP_I)  ||
                     (operation == OP_BEQ) || (operation == OP_JAL);
  assign state_dbg = STATE_W'(state_q);

  // Next-state selection; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (operation)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR:   state_d = (operation == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Datapath strobes decoded from the current state; write enables are
  // masked by reset so nothing is written once reset rises.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOP      = 2'b00;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegal_op = ~op_legal;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOP   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOP   = 2'b10;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOP   = 2'b01;
        PCWrite = Zero;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      HALT:     halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      halted     = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (operation)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: two instances, one per
// HALT_ON_ILLEGAL setting, sharing clock, opcode and Zero.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw;
    logic [1:0] res, sa, sb, aop, imm;
    logic       regw, ill, hlt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Zero = 1'b0;
  logic [6:0] operation = OP_LW;

  logic       PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a, illegal_op_a, halted_a;
  logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ALUOP_a, ImmSrc_a;
  logic [3:0] state_a;
  logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, illegal_op_b, halted_b;
  logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ALUOP_b, ImmSrc_b;
  logic [3:0] state_b;

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0), .STATE_W(4)) dut0 (
    .clk(clk), .reset(reset), .operation(operation), .Zero(Zero),
    .PCWrite(PCWrite_a), .AdrSrc(AdrSrc_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a),
    .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .ALUOP(ALUOP_a),
    .ImmSrc(ImmSrc_a), .RegWrite(RegWrite_a), .illegal_op(illegal_op_a),
    .halted(halted_a), .state_dbg(state_a));

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1), .STATE_W(4)) dut1 (
    .clk(clk), .reset(reset), .operation(operation), .Zero(Zero),
    .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
    .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ALUOP(ALUOP_b),
    .ImmSrc(ImmSrc_b), .RegWrite(RegWrite_b), .illegal_op(illegal_op_b),
    .halted(halted_b), .state_dbg(state_b));

  always #5 clk = ~clk;

  exp_t       q0[$];
  exp_t       q1[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         check_en = 1'b0;
  bit         halt1 = 1'b0;
  logic [6:0] prev_op = OP_LW;
  exp_t       act0, act1, e0, e1;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_bad(input logic [6:0] op);
    return !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
  endfunction

  // Expected outputs for a state, written out from the state/output table.
  function automatic exp_t exp_of(input logic [3:0] st, input logic [6:0] op, input logic z);
    exp_t e;
    e = '0;
    e.st  = st;
    e.imm = imm_of(op);
    case (st)
      4'd0:  begin e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.res = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; e.ill = is_bad(op); end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1;
      4'd4:  begin e.res = 2'b01; e.regw = 1; end
      4'd5:  begin e.adr = 1; e.memw = 1; end
      4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      4'd8:  e.regw = 1;
      4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      4'd11: e.hlt = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t rst_exp(input logic [6:0] op);
    exp_t e;
    e = exp_of(4'd0, op, 1'b0);
    e.pcw = 0;
    e.irw = 0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t h;
    h = exp_of(4'd11, 7'd0, 1'b0);
    h.imm = e.imm;
    q0.push_back(e);
    q1.push_back(halt1 ? h : e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Runs one instruction from its FETCH cycle; the state path is hand-written.
  task automatic instr(input logic [6:0] op, input logic z);
    logic [19:0] path;
    int len;
    case (op)
      OP_LW:   begin path = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};  len = 5; end
      OP_SW:   begin path = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0};  len = 4; end
      OP_R:    begin path = {4'd0, 4'd1, 4'd6, 4'd8, 4'd0};  len = 4; end
      OP_I:    begin path = {4'd0, 4'd1, 4'd7, 4'd8, 4'd0};  len = 4; end
      OP_BEQ:  begin path = {4'd0, 4'd1, 4'd9, 4'd0, 4'd0};  len = 3; end
      OP_JAL:  begin path = {4'd0, 4'd1, 4'd10, 4'd8, 4'd0}; len = 4; end
      default: begin path = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0};  len = 2; end
    endcase
    for (int i = 0; i < len; i++) begin
      push(exp_of(path[4*(4-i) +: 4], (i == 0) ? prev_op : op, z));
      @(posedge clk); #1;
      if (i == 0) begin
        operation = op;
        Zero = z;
      end
    end
    prev_op = op;
    if (is_bad(op)) halt1 = 1'b1;
  endtask

  // Monitor: every cycle each instance presents a full output vector.
  always @(negedge clk) begin
    if (check_en) begin
      cyc++;
      act0 = {state_a, PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, ResultSrc_a, ALUSrcA_a,
              ALUSrcB_a, ALUOP_a, ImmSrc_a, RegWrite_a, illegal_op_a, halted_a};
      act1 = {state_b, PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, ResultSrc_b, ALUSrcA_b,
              ALUSrcB_b, ALUOP_b, ImmSrc_b, RegWrite_b, illegal_op_b, halted_b};
      n_checks += 2;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_sb_empty: cycle %0d got %h, expected an entry", cyc, act0);
      end else begin
        e0 = q0.pop_front();
        if (act0 !== e0) begin
          n_fail++;
          $display("FAIL dut0_outputs cycle %0d: got %h, expected %h", cyc, act0, e0);
        end
      end
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_sb_empty: cycle %0d got %h, expected an entry", cyc, act1);
      end else begin
        e1 = q1.pop_front();
        if (act1 !== e1) begin
          n_fail++;
          $display("FAIL dut1_outputs cycle %0d: got %h, expected %h", cyc, act1, e1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    check_en = 1'b1;
    repeat (3) begin
      push(rst_exp(OP_LW));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    prev_op = OP_LW;

    instr(OP_LW, 1'b1);
    instr(OP_SW, 1'b1);
    instr(OP_BEQ, 1'b1);
    instr(OP_BEQ, 1'b0);
    instr(OP_R, 1'b1);
    instr(OP_I, 1'b0);
    instr(OP_JAL, 1'b1);
    instr(OP_BAD, 1'b0);
    instr(OP_LW, 1'b0);
    instr(OP_SW, 1'b0);
    instr(OP_R, 1'b0);
    instr(OP_JAL, 1'b0);

    // sw aborted by an asynchronous reset while in MEMWRITE
    push(exp_of(4'd0, prev_op, 1'b0));
    @(posedge clk); #1;
    operation = OP_SW;
    push(exp_of(4'd1, OP_SW, 1'b0));
    @(posedge clk); #1;
    push(exp_of(4'd2, OP_SW, 1'b0));
    @(posedge clk); #2;
    check("memwrite_before_reset", {state_a, MemWrite_a, AdrSrc_a}, {4'd5, 1'b1, 1'b1});
    #1 reset = 1'b1;
    #1;
    check("memwrite_drops", {31'd0, MemWrite_a}, 32'd0);
    check("state_async_reset", {28'd0, state_a}, 32'd0);
    check("halt_cleared_by_reset", {state_b, halted_b}, {4'd0, 1'b0});
    halt1 = 1'b0;
    push(rst_exp(OP_SW));
    @(posedge clk); #1;
    push(rst_exp(OP_SW));
    @(posedge clk); #1;
    reset = 1'b0;
    prev_op = OP_SW;
    instr(OP_R, 1'b0);
    instr(OP_BEQ, 1'b1);

    check_en = 1'b0;
    check("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequential control unit for the multicycle RV32I core. It takes the opcode from the instruction register and the ALU Zero flag, and steps through one state per clock.
- Drives the datapath strobes (PC, IR, memory, register file, ALU operand muxes, result mux) as Moore outputs of the current state. The ALU funct decode stays in the separate ALU decoder, driven by ALUOP.
- Supported: lw, sw, R-type, I-type ALU, beq, jal. Any other opcode is flagged as illegal.

Parameters:
- HALT_ON_ILLEGAL, 0, 1 = an illegal opcode enters the sticky HALT state; 0 = report the illegal opcode and return to FETCH.
- STATE_W, 4, width of the state register and of the state_dbg output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- operation  input  7  opcode, instr[6:0], from the instruction register
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU operand A mux: 00 = PC, 01 = OldPC, 10 = rs1 data
- ALUSrcB  output  2  ALU operand B mux: 00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ALUOP  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct fields
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  output  1  register file write enable
- illegal_op  output  1  one-cycle pulse when an illegal opcode is decoded
- halted  output  1  high while in the HALT state
- state_dbg  output  STATE_W  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11.
- Reset: asynchronous; state becomes FETCH immediately.
  - While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - illegal_op=0 and halted=0 during reset; all other outputs show their FETCH values.
  - Reset asserted in any state aborts the instruction; no write strobe is asserted after reset rises.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by operation:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other value -> HALT if HALT_ON_ILLEGAL=1, else FETCH
  - MEMADR: operation 0000011 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
  - HALT -> HALT; it is left only by reset.
- Outputs per state. Defaults: every enable 0, AdrSrc=0, ResultSrc=00, ALUSrcA=00, ALUSrcB=00, ALUOP=00.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01; this precomputes the branch target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOP=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOP=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOP=01, PCWrite=Zero (combinational in this cycle).
  - JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1.
  - HALT: every enable 0, halted=1.
- ImmSrc is combinational from operation in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other value -> 00
- illegal_op is high only in DECODE and only for an unsupported opcode, so it is a single-cycle pulse.
- operation may change only on the clock edge that ends FETCH, because IRWrite is active only in FETCH. The FSM relies on operation staying stable from DECODE to the end of the instruction.
- Cycle counts from FETCH to the next FETCH:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - illegal opcode with HALT_ON_ILLEGAL=0: 2
- Zero is sampled only in BEQ; its value in any other state has no effect.

Test Plan:
- Reset held 3 cycles, then released with operation=0000011.
  - During reset: all write enables 0, state_dbg=0.
  - After release: state_dbg sequence 0,1,2,3,4,0.
  - RegWrite=1 and ResultSrc=01 only in state 4.
- operation=0100011 (sw).
  - state_dbg sequence 0,1,2,5,0.
  - MemWrite=1 and AdrSrc=1 only in state 5.
  - ImmSrc=01 throughout.
- operation=1100011 (beq), run once with Zero=1 and once with Zero=0.
  - PCWrite=1 in BEQ only when Zero=1; PCWrite=0 in BEQ when Zero=0.
  - Both runs return to FETCH after 3 cycles.
- operation=0110011, then 0010011, then 1101111.
  - ALUSrcB in the execute state: 00, 01 and 10 respectively.
  - ALUOP: 10, 10 and 00 respectively.
  - Each instruction ends with ALUWB (RegWrite=1), 4 cycles per instruction.
- operation=1111111.
  - With HALT_ON_ILLEGAL=0: illegal_op pulses for 1 cycle in DECODE, then FETCH.
  - With HALT_ON_ILLEGAL=1: state_dbg=11 and halted=1 hold for 10 or more cycles, and only reset clears them.
- Reset asserted mid-instruction, asynchronously in MEMWRITE.
  - MemWrite drops immediately.
  - state_dbg=0 without waiting for a clock edge.
